// File: rtl/uart_bus_master_if.sv
// MMIO bus bundle between the UART debug bridge (master)
// and the peripheral fabric (slave).
interface uart_bus_master_if #(
  parameter int ADDR_W = 16
);
  logic              sel;
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic [15:0]       rdata;
  logic              rdy;

  modport master (
    output sel,
    output we,
    output re,
    output addr,
    output wdata,
    input  rdata,
    input  rdy
  );

  modport slave (
    input  sel,
    input  we,
    input  re,
    input  addr,
    input  wdata,
    output rdata,
    output rdy
  );
endinterface

// File: rtl/uart_bus_master.sv
// Host-debug bridge: UART command frames in, one MMIO
// read/write on the bus, UART response bytes out.
module uart_bus_master #(
  parameter int ADDR_W        = 16,
  parameter int BUS_TIMEOUT   = 1024,
  parameter int FRAME_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  uart_bus_master_if.master bus,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam int BT_W = $clog2(BUS_TIMEOUT + 1);
  localparam int FT_W = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [BT_W-1:0] BT_LAST =
    BT_W'(BUS_TIMEOUT - 1);
  localparam logic [FT_W-1:0] FT_LAST =
    FT_W'(FRAME_TIMEOUT - 1);

  localparam logic [7:0] OP_W  = 8'h57;
  localparam logic [7:0] OP_R  = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_Q = 8'h3F;
  localparam logic [7:0] RSP_T = 8'h54;

  typedef enum logic [3:0] {
    IDLE,
    GET_AH,
    GET_AL,
    GET_DH,
    GET_DL,
    BUS,
    TX_B0,
    TX_WAIT,
    TX_B1
  } state_e;

  state_e            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic [BT_W-1:0]   bcnt_q, bcnt_d;
  logic [FT_W-1:0]   fcnt_q, fcnt_d;
  logic [7:0]        resp0_q, resp0_d;
  logic [7:0]        resp1_q, resp1_d;
  logic              two_q, two_d;
  logic [1:0]        ign_q, ign_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        err_q, err_d;
  logic              err_inc;
  logic              in_get;
  logic              frame_to;

  assign in_get = (state_q == GET_AH) ||
                  (state_q == GET_AL) ||
                  (state_q == GET_DH) ||
                  (state_q == GET_DL);

  assign frame_to = in_get && !rx_valid &&
                    (fcnt_q == FT_LAST);

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    we_d       = we_q;
    re_d       = re_q;
    bcnt_d     = bcnt_q;
    resp0_d    = resp0_q;
    resp1_d    = resp1_q;
    two_d      = two_q;
    ign_d      = ign_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_inc    = 1'b0;

    // Idle gap between frame bytes; cleared by any byte.
    fcnt_d = (in_get && !rx_valid) ?
             fcnt_q + FT_W'(1) : '0;

    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_W || rx_data == OP_R) begin
            is_wr_d = (rx_data == OP_W);
            state_d = GET_AH;
          end else begin
            resp0_d = RSP_Q;
            two_d   = 1'b0;
            err_inc = 1'b1;
            state_d = TX_B0;
          end
        end
      end
      GET_AH: begin
        if (rx_valid) begin
          addr_d[15:8] = rx_data;
          state_d      = GET_AL;
        end else if (frame_to) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end
      end
      GET_AL: begin
        if (rx_valid) begin
          addr_d[7:0] = rx_data;
          state_d     = is_wr_q ? GET_DH : BUS;
        end else if (frame_to) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end
      end
      GET_DH: begin
        if (rx_valid) begin
          wdata_d[15:8] = rx_data;
          state_d       = GET_DL;
        end else if (frame_to) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end
      end
      GET_DL: begin
        if (rx_valid) begin
          wdata_d[7:0] = rx_data;
          state_d      = BUS;
        end else if (frame_to) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end
      end
      BUS: begin
        if (!sel_q) begin
          sel_d  = 1'b1;
          we_d   = is_wr_q;
          re_d   = !is_wr_q;
          bcnt_d = '0;
        end else if (bus.rdy) begin
          sel_d   = 1'b0;
          we_d    = 1'b0;
          re_d    = 1'b0;
          state_d = TX_B0;
          if (is_wr_q) begin
            resp0_d = RSP_K;
            two_d   = 1'b0;
          end else begin
            resp0_d = bus.rdata[15:8];
            resp1_d = bus.rdata[7:0];
            two_d   = 1'b1;
          end
        end else if (bcnt_q == BT_LAST) begin
          sel_d   = 1'b0;
          we_d    = 1'b0;
          re_d    = 1'b0;
          resp0_d = RSP_T;
          two_d   = 1'b0;
          err_inc = 1'b1;
          state_d = TX_B0;
        end else begin
          bcnt_d = bcnt_q + BT_W'(1);
        end
      end
      TX_B0: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = resp0_q;
          ign_d      = 2'd2;
          state_d    = two_q ? TX_WAIT : IDLE;
        end
      end
      TX_WAIT: begin
        // Let the transmitter raise tx_busy before trusting it.
        if (ign_q != 2'd0) begin
          ign_d = ign_q - 2'd1;
        end else if (!tx_busy) begin
          state_d = TX_B1;
        end
      end
      TX_B1: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = resp1_q;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    err_d = (err_inc && err_q != 8'hFF) ?
            err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      bcnt_q     <= '0;
      fcnt_q     <= '0;
      resp0_q    <= '0;
      resp1_q    <= '0;
      two_q      <= 1'b0;
      ign_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      re_q       <= re_d;
      bcnt_q     <= bcnt_d;
      fcnt_q     <= fcnt_d;
      resp0_q    <= resp0_d;
      resp1_q    <= resp1_d;
      two_q      <= two_d;
      ign_q      <= ign_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.we    = we_q;
  assign bus.re    = re_q;
  assign bus.addr  = addr_q[ADDR_W-1:0];
  assign bus.wdata = wdata_q;

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign busy      = (state_q != IDLE);
  assign err_count = err_q;

endmodule
